irq_sched: RTL
==============

Name: irq_sched

Overview:
- Interrupt scheduler between the peripheral interrupt flags (GPIO irq0/irq6/irq7, timers, UART) and the CPU interrupt request/acknowledge handshake.
- Masks and prioritises up to 8 sticky peripheral flags, presents one request plus vector to the CPU, and tracks in-service state until end-of-interrupt (EOI).
- For sources whose flag lives in the GPIO block, it auto-clears the flag after acknowledge. It does this by arbitrating the GPIO register bus against the CPU and writing the GPIO IRQ-clear register.

Parameters:
- VEC_BASE, 8'h20: vector base. vector = {VEC_BASE[7:3], idx[2:0]}.
- CLR_MAP, 8'hC1: sources whose flag is cleared by a write to the GPIO block.
- GPIO_IRQ_ADDR, 4'd7: GPIO register address of the IRQ-clear register.

Ports:
- clk_i in 1: clock.
- rst_n in 1: reset, asynchronous, active-low.
- irq_src in 8: level/sticky peripheral flags. Bit i is source i; 0 is highest priority.
- addr in 2: own register select.
- data_in in 8: CPU write data.
- data_out out 8: registered read data.
- bus_cyc in 1: own register access strobe.
- bus_we in 1: write enable.
- int_req out 1: interrupt request to CPU.
- int_ack in 1: one-cycle acknowledge from CPU.
- int_vec out 8: vector, valid while int_req is high.
- cpu_g_cyc in 1: CPU access to the GPIO block.
- cpu_g_we in 1: CPU write enable to GPIO.
- cpu_g_addr in 4: CPU address to GPIO.
- cpu_g_data in 8: CPU write data to GPIO.
- g_cyc out 1: muxed GPIO bus strobe.
- g_we out 1: muxed GPIO write enable.
- g_addr out 4: muxed GPIO address.
- g_data out 8: muxed GPIO write data.

Behaviour:
- Reset (async, rst_n=0):
  - MASK=0, INSVC=0, CTRL=0, state IDLE.
  - data_out=0, int_req=0, int_vec=0, internal clear request cleared.
- Registers (bus_cyc, addr):
  - 0 MASK: R/W.
  - 1 PEND: read-only, = irq_src & MASK.
  - 2 INSVC: read; write-1-to-clear = EOI.
  - 3 CTRL: bit0 GEN (global enable), R/W; other bits read 0.
  - Read data registered, 1-cycle latency.
- Request selection: eligible = PEND & ~INSVC. best = lowest set index of eligible. Preemption rule applies, see Optional Feature.
- States: IDLE, REQ, CLR.
- IDLE:
  - If GEN and eligible≠0 and the preemption rule allows, latch idx=best.
  - Next cycle: int_req=1, int_vec=VEC_BASE|idx → REQ.
- REQ:
  - int_req held. idx re-evaluated each cycle while unacknowledged, so a higher-priority arrival replaces the vector.
  - If the current source drops (masked or flag gone) with nothing else eligible: int_req=0 → IDLE.
  - On int_ack: int_req=0 next cycle, INSVC[idx]=1. If CLR_MAP[idx] → CLR, else → IDLE.
  - int_ack while int_req=0 is ignored.
- CLR:
  - Wait for a cycle with cpu_g_cyc=0, then drive g_cyc=1, g_we=1, g_addr=GPIO_IRQ_ADDR, g_data=1<<idx for exactly that cycle → IDLE.
- GPIO bus mux:
  - CPU has absolute priority. CLR owns the bus only when cpu_g_cyc=0.
  - Otherwise g_* equal cpu_g_* combinationally.
  - Never two owners in one cycle; the CPU is never stalled.
- EOI write coinciding with an int_ack of the same idx: set wins.
- A source stays blocked while its INSVC bit is set, so a stale GPIO flag before the clear lands cannot re-request.
- GEN=0: no new requests. An outstanding REQ is withdrawn next cycle (int_req=0 → IDLE). INSVC is unchanged.
- Reset mid-CLR: the clear write is abandoned and the GPIO flag remains set.

Optional Feature:
- Macro IRQ_SCHED_PREEMPT_EN.
- Defined: nesting allowed. A request is issued when best is strictly higher priority (lower index) than the highest-priority INSVC bit, or INSVC=0.
- Undefined: no request while INSVC≠0. A single level of service only.

Test Plan:
- MASK=8'h01, GEN=1, irq_src=8'h01 → int_req=1 within 2 cycles, int_vec=8'h20. int_ack → INSVC=8'h01; one cycle with cpu_g_cyc=0 gives g_cyc=1, g_we=1, g_addr=7, g_data=8'h01.
- irq_src=8'hC0, MASK=8'hFF → int_vec=8'h26. Raise bit1 before ack → int_vec=8'h21. Ack → INSVC=8'h02 and no GPIO clear write (CLR_MAP bit1=0).
- CLR pending with cpu_g_cyc=1 for 5 cycles (addr 3, data 8'h55) → g_* mirror the CPU for those 5 cycles; the clear write appears on cycle 6.
- With IRQ_SCHED_PREEMPT_EN and INSVC=8'h40, irq_src bit0 set → new request, int_vec=8'h20. Without the macro → no request until write INSVC 8'h40 (EOI).
- In REQ, write CTRL=0 → int_req=0 next cycle, INSVC unchanged. Assert rst_n=0 asynchronously mid-CLR → all outputs 0 immediately, and no g_cyc is asserted afterwards.

Source files
------------

// File: rtl/irq_sched.sv
// ----------------------------------------------------------------------------
// irq_sched : interrupt scheduler between the peripheral IRQ flags and the
//             CPU request/acknowledge handshake.
//
// Masks and prioritises up to 8 sticky flags and presents one request plus
// vector to the CPU. It tracks in-service sources until EOI. For sources
// whose flag lives in the GPIO block, it writes the GPIO IRQ-clear register
// after acknowledge. That write borrows the GPIO bus only in cycles the CPU
// leaves idle.
//
// Optional feature: define IRQ_SCHED_PREEMPT_EN to allow nested service.
// A request is then issued when the best source outranks every in-service
// source. When it is undefined, no request is issued while any source is in
// service.
//
// Ports:
//   clk_i, rst_n                    clock, asynchronous active-low reset
//   irq_src[7:0]                    sticky peripheral flags, bit 0 highest
//   addr, data_in, bus_cyc, bus_we  own register access
//                                   (0 MASK, 1 PEND, 2 INSVC/EOI, 3 CTRL)
//   data_out[7:0]                   registered read data, 1-cycle latency
//   int_req, int_vec, int_ack       CPU interrupt handshake
//   cpu_g_*                         CPU side of the GPIO register bus
//   g_*                             muxed GPIO register bus
// ----------------------------------------------------------------------------
module irq_sched #(
    parameter logic [7:0] VEC_BASE      = 8'h20,
    parameter logic [7:0] CLR_MAP       = 8'hC1,
    parameter logic [3:0] GPIO_IRQ_ADDR = 4'd7
) (
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic [7:0] irq_src,
    input  logic [1:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    input  logic       bus_cyc,
    input  logic       bus_we,
    output logic       int_req,
    input  logic       int_ack,
    output logic [7:0] int_vec,
    input  logic       cpu_g_cyc,
    input  logic       cpu_g_we,
    input  logic [3:0] cpu_g_addr,
    input  logic [7:0] cpu_g_data,
    output logic       g_cyc,
    output logic       g_we,
    output logic [3:0] g_addr,
    output logic [7:0] g_data
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_CLR} state_t;

    state_t     state_reg;
    logic [7:0] mask_reg;
    logic [7:0] insvc_reg;
    logic [7:0] insvc_next;
    logic       gen_reg;
    logic [2:0] idx_reg;
    logic       int_req_reg;
    logic [7:0] int_vec_reg;
    logic [7:0] data_out_reg;

    logic [7:0] pend;
    logic [7:0] eligible;
    logic [7:0] allow_mask;
    logic [7:0] cand;
    logic [7:0] first_hot;
    logic [2:0] best_idx;
    logic       cand_any;
    logic       wr_en;
    logic       ack_take;
    logic       clr_fire;
    logic [7:0] rd_mux;

    assign pend     = irq_src & mask_reg;
    assign eligible = pend & ~insvc_reg;

`ifdef IRQ_SCHED_PREEMPT_EN
    // Isolate the highest-priority in-service bit; only strictly lower
    // indices may request. With nothing in service, (0 - 1) opens all bits.
    logic [7:0] insvc_low;
    assign insvc_low  = insvc_reg & (~insvc_reg + 8'd1);
    assign allow_mask = insvc_low - 8'd1;
`else
    assign allow_mask = (insvc_reg == 8'd0) ? 8'hFF : 8'h00;
`endif

    assign cand     = eligible & allow_mask;
    assign cand_any = |cand;

    // One-hot of the lowest set candidate bit.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_first
            if (gi == 0) begin : g_lsb
                assign first_hot[gi] = cand[0];
            end else begin : g_upper
                assign first_hot[gi] = cand[gi] & ~(|cand[gi-1:0]);
            end
        end
    endgenerate

    always_comb begin
        best_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (first_hot[i]) best_idx = best_idx | 3'(i);
        end
    end

    assign wr_en = bus_cyc & bus_we;
    // int_req is high exactly in REQ, so an ack outside REQ is ignored.
    assign ack_take = (state_reg == ST_REQ) && int_ack;
    assign clr_fire = (state_reg == ST_CLR) && !cpu_g_cyc;

    // EOI clears first, so an ack of the same index in the same cycle wins.
    always_comb begin
        insvc_next = insvc_reg;
        if (wr_en && addr == 2'd2) insvc_next = insvc_next & ~data_in;
        if (ack_take)              insvc_next[idx_reg] = 1'b1;
    end

    always_comb begin
        rd_mux = 8'd0;
        case (addr)
            2'd0: rd_mux = mask_reg;
            2'd1: rd_mux = pend;
            2'd2: rd_mux = insvc_reg;
            2'd3: rd_mux = {7'd0, gen_reg};
            default: rd_mux = 8'd0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            mask_reg     <= 8'd0;
            insvc_reg    <= 8'd0;
            gen_reg      <= 1'b0;
            data_out_reg <= 8'd0;
        end else begin
            insvc_reg <= insvc_next;
            if (wr_en && addr == 2'd0) mask_reg <= data_in;
            if (wr_en && addr == 2'd3) gen_reg  <= data_in[0];
            if (bus_cyc && !bus_we)    data_out_reg <= rd_mux;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            idx_reg     <= 3'd0;
            int_req_reg <= 1'b0;
            int_vec_reg <= 8'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (gen_reg && cand_any) begin
                        idx_reg     <= best_idx;
                        int_req_reg <= 1'b1;
                        int_vec_reg <= {VEC_BASE[7:3], best_idx};
                        state_reg   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (int_ack) begin
                        int_req_reg <= 1'b0;
                        state_reg   <= CLR_MAP[idx_reg] ? ST_CLR : ST_IDLE;
                    end else if (!gen_reg || !cand_any) begin
                        int_req_reg <= 1'b0;
                        state_reg   <= ST_IDLE;
                    end else begin
                        // Unacknowledged: follow the current best source.
                        idx_reg     <= best_idx;
                        int_vec_reg <= {VEC_BASE[7:3], best_idx};
                    end
                end
                ST_CLR: begin
                    if (!cpu_g_cyc) state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // The CPU always owns the GPIO bus when it drives a cycle; the clear
    // write only takes idle cycles.
    always_comb begin
        g_cyc  = cpu_g_cyc;
        g_we   = cpu_g_we;
        g_addr = cpu_g_addr;
        g_data = cpu_g_data;
        if (clr_fire) begin
            g_cyc  = 1'b1;
            g_we   = 1'b1;
            g_addr = GPIO_IRQ_ADDR;
            g_data = 8'd1 << idx_reg;
        end
    end

    assign int_req  = int_req_reg;
    assign int_vec  = int_vec_reg;
    assign data_out = data_out_reg;

endmodule
